// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - read, write-back and reserve bus of the register file
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [2**ADDR_W-1:0]     busy_vec;

  modport master (
    output rd_en, rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, we, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - N-read/1-write register file with optional bypass and busy scoreboard
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic            clock,
  input logic            resetn,
  regfile_param_if.slave bus
);
  localparam int   DEPTH = 2**ADDR_W;
  localparam logic ZR    = (ZERO_REG != 0);
  localparam logic BP    = (BYPASS != 0);

  logic [DATA_W-1:0]        r_regs [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_busy;

  logic                     w_wr_ok;
  logic                     w_rsv_ok;
  logic [DEPTH-1:0]         w_busy_nxt;
  logic [NUM_RD*DATA_W-1:0] w_rd_data_nxt;
  logic [NUM_RD-1:0]        w_rd_busy_nxt;

  assign w_wr_ok  = bus.we && !(ZR && bus.wr_addr == '0);
  assign w_rsv_ok = bus.rsv_en && !(ZR && bus.rsv_addr == '0);

  // Reserve is applied after the clear so a new producer on the same address wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.we)   w_busy_nxt[bus.wr_addr]  = 1'b0;
    if (w_rsv_ok) w_busy_nxt[bus.rsv_addr] = 1'b1;
  end

  always_comb begin
    w_rd_data_nxt = r_rd_data;
    w_rd_busy_nxt = r_rd_busy;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_en[i]) begin
        if (ZR && bus.rd_addr[i*ADDR_W +: ADDR_W] == '0)
          w_rd_data_nxt[i*DATA_W +: DATA_W] = '0;
        else if (BP && w_wr_ok && bus.wr_addr == bus.rd_addr[i*ADDR_W +: ADDR_W])
          w_rd_data_nxt[i*DATA_W +: DATA_W] = bus.wr_data;
        else
          w_rd_data_nxt[i*DATA_W +: DATA_W] = r_regs[bus.rd_addr[i*ADDR_W +: ADDR_W]];
        w_rd_busy_nxt[i] = r_busy[bus.rd_addr[i*ADDR_W +: ADDR_W]] &&
                           !(BP && bus.we && bus.wr_addr == bus.rd_addr[i*ADDR_W +: ADDR_W]);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
      r_busy    <= '0;
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      if (w_wr_ok) r_regs[bus.wr_addr] <= bus.wr_data;
      r_busy    <= w_busy_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_rd_busy <= w_rd_busy_nxt;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_busy  = r_rd_busy;
  assign bus.busy_vec = r_busy;
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param, bypass and non-bypass instances
module tb_regfile_param;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]      en;
  logic [3:0][4:0] ra;
  logic            we;
  logic [4:0]      wa;
  logic [31:0]     wd;
  logic            rsv;
  logic [4:0]      rsa;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus0 ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus1 ();

  assign bus0.rd_en = en;  assign bus0.rd_addr = ra;  assign bus0.we = we;
  assign bus0.wr_addr = wa; assign bus0.wr_data = wd; assign bus0.rsv_en = rsv;
  assign bus0.rsv_addr = rsa;
  assign bus1.rd_en = en;  assign bus1.rd_addr = ra;  assign bus1.we = we;
  assign bus1.wr_addr = wa; assign bus1.wr_data = wd; assign bus1.rsv_en = rsv;
  assign bus1.rsv_addr = rsa;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clock(clock), .resetn(resetn), .bus(bus0));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clock(clock), .resetn(resetn), .bus(bus1));

  typedef struct packed {
    logic [1:0][127:0] d;
    logic [1:0][3:0]   b;
    logic [1:0][31:0]  bv;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state per instance: 0 = zero-reg + bypass, 1 = neither.
  logic [31:0] mreg  [2][32];
  bit          mbusy [2][32];
  logic [31:0] mout_d[2][4];
  bit          mout_b[2][4];

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 32; k++) begin mreg[c][k] = '0; mbusy[c][k] = 0; end
      for (int p = 0; p < 4; p++) begin mout_d[c][p] = '0; mout_b[c][p] = 0; end
    end
  endtask

  task automatic idle();
    en = '0; we = 1'b0; rsv = 1'b0;
  endtask

  // Apply current inputs for one edge: predict, enqueue, advance to next falling edge.
  task automatic tick();
    exp_t e;
    bit zr, bp, wok;
    for (int c = 0; c < 2; c++) begin
      zr  = (c == 0);
      bp  = (c == 0);
      wok = we && !(zr && wa == 0);
      for (int p = 0; p < 4; p++) begin
        if (en[p]) begin
          if (zr && ra[p] == 0)                mout_d[c][p] = '0;
          else if (bp && wok && wa == ra[p])   mout_d[c][p] = wd;
          else                                 mout_d[c][p] = mreg[c][ra[p]];
          mout_b[c][p] = mbusy[c][ra[p]] && !(bp && we && wa == ra[p]);
        end
      end
      if (wok) mreg[c][wa] = wd;
      if (we)  mbusy[c][wa] = 0;
      if (rsv && !(zr && rsa == 0)) mbusy[c][rsa] = 1;
      for (int p = 0; p < 4; p++) begin
        e.d[c][p*32 +: 32] = mout_d[c][p];
        e.b[c][p]          = mout_b[c][p];
      end
      for (int k = 0; k < 32; k++) e.bv[c][k] = mbusy[c][k];
    end
    sbq.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp("dut0 rd_data",  bus0.rd_data,  e.d[0]);
        cmp("dut0 rd_busy",  bus0.rd_busy,  e.b[0]);
        cmp("dut0 busy_vec", bus0.busy_vec, e.bv[0]);
        cmp("dut1 rd_data",  bus1.rd_data,  e.d[1]);
        cmp("dut1 rd_busy",  bus1.rd_busy,  e.b[1]);
        cmp("dut1 busy_vec", bus1.busy_vec, e.bv[1]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    idle(); ra = '0; wa = '0; wd = '0; rsa = '0;
    model_reset();
    @(negedge clock); @(negedge clock);
    cmp("reset rd_data",  bus0.rd_data,  '0);
    cmp("reset busy_vec", bus0.busy_vec, '0);
    resetn = 1'b1;

    idle(); we = 1; wa = 5; wd = 32'hDEADBEEF; rsv = 1; rsa = 7; tick();
    idle(); en = 4'b0001; ra[0] = 5; tick();
    cmp("pre-reset busy7", bus0.busy_vec[7], 1'b1);
    resetn = 1'b0;
    #1;
    cmp("async rst rd_data0",  bus0.rd_data,  '0);
    cmp("async rst rd_busy0",  bus0.rd_busy,  '0);
    cmp("async rst busy_vec0", bus0.busy_vec, '0);
    cmp("async rst rd_data1",  bus1.rd_data,  '0);
    model_reset();
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;
    idle(); en = 4'b0001; ra[0] = 5; tick();
    cmp("reg5 after reset", bus0.rd_data[31:0], 32'h0);

    idle(); we = 1; wa = 3; wd = 32'h12345678; tick();
    idle(); en = 4'b0001; ra[0] = 3; tick();
    cmp("basic read", bus0.rd_data[31:0], 32'h12345678);
    cmp("basic busy", bus0.rd_busy[0], 1'b0);

    idle(); we = 1; wa = 9; wd = 32'hCAFE0001; en = 4'b0010; ra[1] = 9; tick();
    cmp("bypass dut0", bus0.rd_data[63:32], 32'hCAFE0001);
    cmp("no bypass dut1", bus1.rd_data[63:32], 32'h0);

    idle(); we = 1; wa = 0; wd = 32'hFFFFFFFF; rsv = 1; rsa = 0; tick();
    idle(); en = 4'b0001; ra[0] = 0; tick();
    cmp("zero reg read", bus0.rd_data[31:0], 32'h0);
    cmp("zero reg busy", bus0.busy_vec[0], 1'b0);

    idle(); rsv = 1; rsa = 4; tick();
    idle(); en = 4'b0001; ra[0] = 4; tick();
    cmp("rsv read busy", bus0.rd_busy[0], 1'b1);
    idle(); we = 1; wa = 4; wd = 32'h55; rsv = 1; rsa = 4; tick();
    cmp("set wins", bus0.busy_vec[4], 1'b1);
    idle(); we = 1; wa = 4; wd = 32'h55; en = 4'b0001; ra[0] = 4; tick();
    cmp("retire busy_vec", bus0.busy_vec[4], 1'b0);
    cmp("retire data", bus0.rd_data[31:0], 32'h55);
    cmp("retire rd_busy", bus0.rd_busy[0], 1'b0);

    idle(); we = 1; wa = 2; wd = 32'hA5A5A5A5; tick();
    idle(); en = 4'b1111; ra = {5'd2, 5'd2, 5'd2, 5'd2}; tick();
    cmp("four ports equal", bus0.rd_data, {4{32'hA5A5A5A5}});
    idle(); en = 4'b1011; ra[2] = 6; tick();
    cmp("port2 hold", bus0.rd_data[95:64], 32'hA5A5A5A5);

    for (int n = 0; n < 400; n++) begin
      en  = 4'($urandom);
      for (int p = 0; p < 4; p++) ra[p] = 5'($urandom_range(0, 7));
      we  = 1'($urandom);
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wd  = $urandom;
      rsv = 1'($urandom);
      rsa = 5'($urandom_range(0, 7));
      tick();
    end
    idle(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file for the processor datapath with N synchronous read ports, one write port, optional same-cycle write-to-read bypass and a per-register busy scoreboard for pending writes. Sits between decode and execute: decode presents source addresses and reserves the destination; write-back retires the result and clears the reservation. Replaces the fixed 32×32, two-read, split-edge register file with a single-edge design.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, if 1 register 0 reads as 0, ignores writes, is never busy
- BYPASS, 1, if 1 a same-cycle write is forwarded to matching read ports

- clock  in  1  sole clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port i data at bits [i*DATA_W +: DATA_W], registered
- rd_busy  out  NUM_RD  port i operand still pending, registered with rd_data
- we  in  1  write-back enable
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back value
- rsv_en  in  1  reserve destination (mark busy)
- rsv_addr  in  ADDR_W  destination to reserve
- busy_vec  out  2**ADDR_W  current scoreboard, bit k = register k busy

## Operation
- Reset (resetn low, asynchronous): all registers 0, busy_vec 0, rd_data 0, rd_busy 0. Held while resetn low; first update on first rising edge after release.
- Write: on rising edge with we=1, reg[wr_addr] <= wr_data. Dropped when ZERO_REG=1 and wr_addr=0.
- Read, per port i with rd_en[i]=1, on rising edge:
  - rd_data[i] <= wr_data if BYPASS=1, we=1, wr_addr=rd_addr[i] and address not suppressed by ZERO_REG; else reg[rd_addr[i]]; 0 for address 0 when ZERO_REG=1.
  - rd_busy[i] <= busy[rd_addr[i]] AND NOT (we=1 AND wr_addr=rd_addr[i] AND BYPASS=1). With BYPASS=0, busy is sampled pre-clear.
- rd_en[i]=0: rd_data[i], rd_busy[i] hold previous values.
- Scoreboard, per rising edge: we=1 clears busy[wr_addr]; rsv_en=1 sets busy[rsv_addr]. Same address both: set wins (new producer outstanding). Address 0 never set when ZERO_REG=1.
- Multiple read ports on the same address return identical data/busy.
- Write to a non-busy register is legal (no error flag); clears nothing extra.
- rsv of an already-busy register: stays busy (no count; one outstanding producer per register is the pipeline's responsibility).

## Timing
- Read latency 1 cycle: address at edge k, data/busy valid after edge k.
- Write visible to reads addressed at same edge when BYPASS=1; otherwise at next edge.
- Reserve visible in busy_vec after the edge; to a read at the same edge it is not visible (read sees pre-edge busy).
- busy_vec is a direct register output, no combinational path from inputs.
- No combinational input-to-output path on any port.

## Test plan
- Reset: drive resetn=0 mid-run after writing reg5=0xDEADBEEF and reserving reg7 -> immediately rd_data=0, rd_busy=0, busy_vec=0; read reg5 after release -> 0x00000000.
- Basic write/read: write reg3=0x12345678, next cycle read port0 addr 3 -> rd_data[0]=0x12345678 one cycle later, rd_busy[0]=0.
- Bypass: same edge we=1 wr_addr=9 wr_data=0xCAFE0001 and rd_addr port1=9 -> rd_data[1]=0xCAFE0001 after that edge; rerun with BYPASS=0 -> old reg9 value (0).
- Zero register: write reg0=0xFFFFFFFF and rsv reg0 -> reads of reg0 return 0, busy_vec[0]=0.
- Scoreboard: rsv reg4, read reg4 next cycle -> rd_busy=1; same edge we reg4=0x55 and rsv reg4 -> busy_vec[4] stays 1; then we reg4 only -> busy_vec[4]=0, read of reg4 at that edge gives 0x55 with rd_busy=0 (BYPASS=1).
- Read hold and port independence: NUM_RD=4, all ports addr 2 after reg2=0xA5A5A5A5 -> all four equal; drop rd_en[2], change its address -> rd_data[2] holds 0xA5A5A5A5.
